// File: rtl/cascaded_modn_counter_pkg.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module  : cascaded_modn_counter_pkg
// Purpose : Shared time-base constants and the count-direction decode used by
//           the cascaded mod-N counter. The time, alarm-set and timer instances
//           take their default moduli from here.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package cascaded_modn_counter_pkg;

   localparam int SEC_MOD     = 60;
   localparam int MIN_MOD     = 60;
   localparam int HR_MOD      = 24;
   localparam int TIME_W      = 6;
   localparam int TIME_STAGES = 3;

   // Packed moduli for sec/min/hr, stage 0 (seconds) in the LSBs.
   localparam logic [TIME_STAGES*TIME_W-1:0] TIME_MODS =
      {TIME_W'(HR_MOD), TIME_W'(MIN_MOD), TIME_W'(SEC_MOD)};

   typedef enum logic [1:0] {
      DIR_HOLD = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DN   = 2'd2
   } dir_e;

   // up and down together cancel out, same as neither.
   function automatic dir_e decode_dir(input logic up, input logic down);
      if (up == down) return DIR_HOLD;
      return up ? DIR_UP : DIR_DN;
   endfunction

endpackage
`default_nettype wire

// File: rtl/counter_modn_stage.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module  : counter_modn_stage
// Purpose : One mod-MOD up/down counter stage of the cascade. Loads (with
//           clamping to MOD-1) take priority over stepping.
// Ports   : clk, reset      clock, async active-high reset
//           step_in         step this stage this cycle
//           dir_up          1 = count up, 0 = count down (only used on step)
//           load_en         load this stage this cycle
//           load_val        value to load (clamped to MOD-1)
//           val             registered stage value
//           step_out        step_in & terminal count for the current direction
// Rev     : 1.0  initial release
// ============================================================================
module counter_modn_stage
   import cascaded_modn_counter_pkg::*;
#(
   parameter int W   = 6,
   parameter int MOD = 60
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         step_in,
   input  logic         dir_up,
   input  logic         load_en,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] val,
   output logic         step_out
);

   localparam logic [W-1:0] c_MAX     = W'(MOD - 1);
   // The modulus may equal 2**W, so the clamp comparison needs one extra bit.
   localparam logic [W:0]   c_MOD_EXT = (W+1)'(MOD);

   logic [W-1:0] r_val;
   logic [W-1:0] w_load_clamped;
   logic [W-1:0] w_next;
   logic         w_terminal;

   always_comb begin
      w_load_clamped = ({1'b0, load_val} >= c_MOD_EXT) ? c_MAX : load_val;
      w_terminal     = dir_up ? (r_val == c_MAX) : (r_val == '0);
      step_out       = step_in & w_terminal;
   end

   always_comb begin
      w_next = r_val;
      if (load_en) begin
         w_next = w_load_clamped;
      end else if (step_in) begin
         if (dir_up) w_next = w_terminal ? '0    : r_val + W'(1);
         else        w_next = w_terminal ? c_MAX : r_val - W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_val <= '0;
      else       r_val <= w_next;
   end

   assign val = r_val;

endmodule
`default_nettype wire

// File: rtl/cascaded_modn_counter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module  : cascaded_modn_counter
// Purpose : STAGES cascaded mod-N up/down counters with per-stage moduli,
//           tick enable, masked clamped load and registered top-stage
//           wrap/underflow pulses. Default moduli give sec/min/hr.
// Ports   : clk, reset      clock, async active-high reset
//           tick            count enable (one step of stage 0 per cycle)
//           up, down        direction; equal values mean hold
//           load            load the stages selected by load_sel
//           load_sel        per-stage load mask
//           load_data       packed load values, stage 0 in LSBs
//           count           packed registered stage values
//           wrap            1-cycle pulse, top stage MOD-1 -> 0
//           underflow       1-cycle pulse, top stage 0 -> MOD-1
// Rev     : 1.0  initial release
// ============================================================================
module cascaded_modn_counter
   import cascaded_modn_counter_pkg::*;
#(
   parameter int                     STAGES = TIME_STAGES,
   parameter int                     W      = TIME_W,
   parameter logic [STAGES*W-1:0]    MODS   = TIME_MODS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tick,
   input  logic                  up,
   input  logic                  down,
   input  logic                  load,
   input  logic [STAGES-1:0]     load_sel,
   input  logic [STAGES*W-1:0]   load_data,
   output logic [STAGES*W-1:0]   count,
   output logic                  wrap,
   output logic                  underflow
);

   dir_e          w_dir;
   logic          w_dir_up;
   logic          w_dir_dn;
   // w_step[i] steps stage i; w_step[STAGES] is the top stage's terminal step.
   logic [STAGES:0] w_step;
   logic          r_wrap;
   logic          r_underflow;

   always_comb begin
      w_dir     = decode_dir(up, down);
      w_dir_up  = (w_dir == DIR_UP);
      w_dir_dn  = (w_dir == DIR_DN);
      // A load cycle suppresses counting in every stage, selected or not.
      w_step[0] = tick & ~load & (w_dir != DIR_HOLD);
   end

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      localparam logic [W-1:0] c_FIELD = MODS[i*W +: W];
      // A modulus of exactly 2**W does not fit in W bits; its field reads 0.
      localparam int           c_MOD   = (c_FIELD == '0) ? (1 << W) : int'(c_FIELD);

      counter_modn_stage #(
         .W   (W),
         .MOD (c_MOD)
      ) u_stage (
         .clk      (clk),
         .reset    (reset),
         .step_in  (w_step[i]),
         .dir_up   (w_dir_up),
         .load_en  (load & load_sel[i]),
         .load_val (load_data[i*W +: W]),
         .val      (count[i*W +: W]),
         .step_out (w_step[i+1])
      );
   end

   // The top stage only steps out when it wraps, so its step_out is the pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wrap      <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_wrap      <= w_step[STAGES] & w_dir_up;
         r_underflow <= w_step[STAGES] & w_dir_dn;
      end
   end

   assign wrap      = r_wrap;
   assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_cascaded_modn_counter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module  : tb_cascaded_modn_counter
// Purpose : Self-checking bench for cascaded_modn_counter: default 60/60/24
//           instance plus a 2-stage mod-10/10, W=4 instance.
// Rev     : 1.0  initial release
// ============================================================================
module tb_cascaded_modn_counter;

   typedef int mods_t [3];

   typedef struct {
      logic        tk, u, d, ld;
      logic [2:0]  sel;
      logic [17:0] data;
      logic [17:0] exp_cnt;
      logic        exp_w, exp_u;
      string       nm;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   logic        tick = 0, up = 0, down = 0, load = 0;
   logic [2:0]  load_sel = '0;
   logic [17:0] load_data = '0;
   logic [17:0] count;
   logic        wrap, underflow;

   logic        b_tick = 0, b_up = 0, b_down = 0, b_load = 0;
   logic [1:0]  b_load_sel = '0;
   logic [7:0]  b_load_data = '0;
   logic [7:0]  b_count;
   logic        b_wrap, b_underflow;

   int checks = 0;
   int failures = 0;
   int ma_total = 0;
   int mb_total = 0;
   mods_t mods_a = '{60, 60, 24};
   mods_t mods_b = '{10, 10, 1};
   vec_t  vecs [15];

   always #5 clk = ~clk;

   cascaded_modn_counter dut_a (
      .clk(clk), .reset(reset), .tick(tick), .up(up), .down(down),
      .load(load), .load_sel(load_sel), .load_data(load_data),
      .count(count), .wrap(wrap), .underflow(underflow));

   cascaded_modn_counter #(.STAGES(2), .W(4), .MODS({4'd10, 4'd10})) dut_b (
      .clk(clk), .reset(reset), .tick(b_tick), .up(b_up), .down(b_down),
      .load(b_load), .load_sel(b_load_sel), .load_data(b_load_data),
      .count(b_count), .wrap(b_wrap), .underflow(b_underflow));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [17:0] hms(input int h, input int m, input int s);
      return {6'(h), 6'(m), 6'(s)};
   endfunction

   function automatic vec_t mkv(input logic tk, u, d, ld, input logic [2:0] sel,
                                input logic [17:0] data, input logic [17:0] ec,
                                input logic ew, eu, input string nm);
      vec_t v;
      v.tk = tk; v.u = u; v.d = d; v.ld = ld; v.sel = sel; v.data = data;
      v.exp_cnt = ec; v.exp_w = ew; v.exp_u = eu; v.nm = nm;
      return v;
   endfunction

   // Reference model: the whole chain is one mixed-radix number in 0..P-1.
   function automatic int prod(input mods_t m, input int n);
      int p = 1;
      for (int i = 0; i < n; i++) p *= m[i];
      return p;
   endfunction

   task automatic model_step(inout int t, input mods_t m, input int n, input int w,
                             input logic tk, u, d, ld, input logic [2:0] sel,
                             input logic [17:0] data, output logic wr, output logic un);
      int p, r, v;
      int dg [3];
      p = prod(m, n);
      wr = 1'b0; un = 1'b0;
      if (ld) begin
         r = 1;
         for (int i = 0; i < n; i++) begin dg[i] = (t / r) % m[i]; r *= m[i]; end
         for (int i = 0; i < n; i++) if (sel[i]) begin
            v = int'((data >> (i*w)) & 18'((1 << w) - 1));
            dg[i] = (v >= m[i]) ? m[i] - 1 : v;
         end
         t = 0; r = 1;
         for (int i = 0; i < n; i++) begin t += dg[i] * r; r *= m[i]; end
      end else if (tk && (u != d)) begin
         if (u) begin wr = (t == p - 1); t = (t + 1) % p; end
         else   begin un = (t == 0);     t = (t + p - 1) % p; end
      end
   endtask

   function automatic logic [17:0] pack(input int t, input mods_t m, input int n, input int w);
      logic [17:0] res = '0;
      int r = 1;
      for (int i = 0; i < n; i++) begin
         res |= 18'((t / r) % m[i]) << (i*w);
         r *= m[i];
      end
      return res;
   endfunction

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic idle_a();
      tick = 0; up = 0; down = 0; load = 0; load_sel = '0; load_data = '0;
   endtask

   task automatic apply_reset();
      idle_a();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      ma_total = 0; mb_total = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic ew, eu;
      int nwraps;

      vecs[0]  = mkv(1,1,0,0,3'b000,'0,               hms(0,0,1),    0,0,"up1");
      vecs[1]  = mkv(1,0,1,0,3'b000,'0,               hms(0,0,0),    0,0,"dn1");
      vecs[2]  = mkv(1,0,1,0,3'b000,'0,               hms(23,59,59), 0,1,"underflow");
      vecs[3]  = mkv(1,1,1,0,3'b000,'0,               hms(23,59,59), 0,0,"both_dirs");
      vecs[4]  = mkv(0,1,0,0,3'b000,'0,               hms(23,59,59), 0,0,"no_tick");
      vecs[5]  = mkv(1,1,0,1,3'b111,hms(23,59,59),    hms(23,59,59), 0,0,"load_wins");
      vecs[6]  = mkv(1,1,0,0,3'b000,'0,               hms(0,0,0),    1,0,"wrap");
      vecs[7]  = mkv(0,0,0,0,3'b000,'0,               hms(0,0,0),    0,0,"wrap_1cyc");
      vecs[8]  = mkv(0,0,0,1,3'b010,hms(5,63,7),      hms(0,59,0),   0,0,"clamp_mid");
      vecs[9]  = mkv(0,0,0,1,3'b101,hms(63,0,63),     hms(23,59,59), 0,0,"clamp_ends");
      vecs[10] = mkv(1,0,1,0,3'b000,'0,               hms(23,59,58), 0,0,"dn_plain");
      vecs[11] = mkv(1,1,1,1,3'b111,hms(12,34,56),    hms(12,34,56), 0,0,"load_inrange");
      vecs[12] = mkv(0,0,0,1,3'b111,hms(0,59,59),     hms(0,59,59),  0,0,"load_carry");
      vecs[13] = mkv(1,1,0,0,3'b000,'0,               hms(1,0,0),    0,0,"carry_chain");
      vecs[14] = mkv(1,0,1,0,3'b000,'0,               hms(0,59,59),  0,0,"borrow_chain");

      apply_reset();
      chk("reset_count", 32'(count), 32'(hms(0,0,0)));
      chk("reset_wrap", 32'(wrap), 32'd0);
      chk("reset_underflow", 32'(underflow), 32'd0);

      foreach (vecs[k]) begin
         tick = vecs[k].tk; up = vecs[k].u; down = vecs[k].d; load = vecs[k].ld;
         load_sel = vecs[k].sel; load_data = vecs[k].data;
         cyc();
         chk({vecs[k].nm, "_count"}, 32'(count), 32'(vecs[k].exp_cnt));
         chk({vecs[k].nm, "_wrap"}, 32'(wrap), 32'(vecs[k].exp_w));
         chk({vecs[k].nm, "_underflow"}, 32'(underflow), 32'(vecs[k].exp_u));
      end

      // 59 seconds, then the minute carry.
      apply_reset();
      tick = 1; up = 1;
      for (int i = 0; i < 59; i++) cyc();
      chk("sec59_count", 32'(count), 32'(hms(0,0,59)));
      cyc();
      chk("min_carry_count", 32'(count), 32'(hms(0,1,0)));
      chk("min_carry_wrap", 32'(wrap), 32'd0);

      // Asynchronous reset mid-cycle.
      idle_a();
      load = 1; load_sel = 3'b111; load_data = hms(5,30,17);
      cyc();
      chk("pre_reset_count", 32'(count), 32'(hms(5,30,17)));
      idle_a();
      #2 reset = 1'b1;
      #1 chk("async_reset_count", 32'(count), 32'd0);
      #1 reset = 1'b0;
      tick = 1; up = 1;
      cyc();
      chk("first_tick_after_reset", 32'(count), 32'(hms(0,0,1)));
      ma_total = 1;

      // Randomized run against the mixed-radix model.
      for (int i = 0; i < 400; i++) begin
         tick = ($urandom_range(3) != 0);
         up = 1'($urandom); down = 1'($urandom);
         load = ($urandom_range(15) == 0);
         load_sel = 3'($urandom); load_data = 18'($urandom);
         if ($urandom_range(7) == 0) begin
            load = 1; load_sel = 3'b111;
            load_data = ($urandom_range(1) != 0) ? hms(23,59,59) : hms(0,0,0);
         end
         model_step(ma_total, mods_a, 3, 6, tick, up, down, load, load_sel, load_data, ew, eu);
         cyc();
         chk("rand_count", 32'(count), 32'(pack(ma_total, mods_a, 3, 6)));
         chk("rand_wrap", 32'(wrap), 32'(ew));
         chk("rand_underflow", 32'(underflow), 32'(eu));
      end

      // Second parameterisation: 100 up ticks return to 0 with one wrap.
      apply_reset();
      nwraps = 0;
      b_tick = 1; b_up = 1; b_down = 0;
      for (int i = 0; i < 100; i++) begin
         cyc();
         if (b_wrap) nwraps++;
         chk("b_underflow_quiet", 32'(b_underflow), 32'd0);
      end
      chk("b_sweep_count", 32'(b_count), 32'd0);
      chk("b_sweep_wraps", 32'(nwraps), 32'd1);
      cyc();
      chk("b_after_sweep", 32'(b_count), 32'h01);

      mb_total = 1;
      for (int i = 0; i < 200; i++) begin
         b_tick = ($urandom_range(3) != 0);
         b_up = 1'($urandom); b_down = 1'($urandom);
         b_load = ($urandom_range(15) == 0);
         b_load_sel = 2'($urandom); b_load_data = 8'($urandom);
         model_step(mb_total, mods_b, 2, 4, b_tick, b_up, b_down, b_load,
                    {1'b0, b_load_sel}, {10'd0, b_load_data}, ew, eu);
         cyc();
         chk("b_rand_count", 32'(b_count), 32'(pack(mb_total, mods_b, 2, 4)));
         chk("b_rand_wrap", 32'(b_wrap), 32'(ew));
         chk("b_rand_underflow", 32'(b_underflow), 32'(eu));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
